// File: rtl/instr_sequencer_if.sv
// Memory handshake bundle between the instruction sequencer and the
// instruction/data memories. The sequencer uses the master side, memories the slave side.
interface instr_sequencer_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_ack, imem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_ack, imem_rdata, dmem_ack
   );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the 16-bit core. Owns PC and IR, runs the
// fetch/data handshakes and sequences ALU, memory, writeback and CPSR update
// from the decoder outputs. Every strobe and request is a registered output.
module instr_sequencer #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter logic [15:0] PC_STEP     = 16'd2,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   instr_sequencer_if.master        mem,
   output logic [15:0]              ir,
   input  logic                     cond_pass,
   input  logic                     is_branch,
   input  logic                     is_link,
   input  logic                     is_ls,
   input  logic                     wr_reg,
   input  logic signed [15:0]       b_offset,
   output logic                     alu_en,
   output logic                     rf_we,
   output logic                     link_we,
   output logic [15:0]              link_val,
   output logic                     cpsr_we,
   output logic [15:0]              pc,
   output logic                     retire,
   output logic                     fault
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT
   } state_t;

   // The wait counter reaching MEM_TIMEOUT is detected one count early so the
   // request is dropped exactly after MEM_TIMEOUT unanswered cycles.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state, state_next;
   logic [15:0] pc_next, ir_next;
   logic [15:0] ir_pc, ir_pc_next;
   logic [7:0]  wait_cnt, wait_next;
   logic        fault_next;
   logic        imem_req_q, imem_req_next;
   logic        dmem_req_q, dmem_req_next;
   logic        dmem_we_q, dmem_we_next;
   logic        alu_en_next, rf_we_next, link_we_next, cpsr_we_next, retire_next;

   assign mem.imem_req  = imem_req_q;
   assign mem.imem_addr = pc;
   assign mem.dmem_req  = dmem_req_q;
   assign mem.dmem_we   = dmem_we_q;
   assign link_val      = ir_pc + PC_STEP;

   // Next-state, next-PC and next-strobe decision for every FSM state.
   always_comb begin
      state_next    = state;
      pc_next       = pc;
      ir_next       = ir;
      ir_pc_next    = ir_pc;
      wait_next     = 8'd0;
      fault_next    = fault;
      imem_req_next = 1'b0;
      dmem_req_next = 1'b0;
      dmem_we_next  = dmem_we_q;
      alu_en_next   = 1'b0;
      rf_we_next    = 1'b0;
      link_we_next  = 1'b0;
      cpsr_we_next  = 1'b0;
      retire_next   = 1'b0;
      case (state)
         S_FETCH: begin
            if (imem_req_q && mem.imem_ack) begin
               ir_next    = mem.imem_rdata;
               ir_pc_next = pc;
               pc_next    = pc + PC_STEP;
               state_next = S_DECODE;
            end else if (imem_req_q && (wait_cnt == TIMEOUT_LAST)) begin
               fault_next = 1'b1;
               state_next = S_FAULT;
            end else begin
               imem_req_next = 1'b1;
               if (imem_req_q) wait_next = wait_cnt + 8'd1;
            end
         end
         S_DECODE: begin
            if (!cond_pass) begin
               retire_next   = 1'b1;
               imem_req_next = 1'b1;
               state_next    = S_FETCH;
            end else begin
               alu_en_next = !is_branch && !is_ls;
               state_next  = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_branch) begin
               pc_next = ir_pc + PC_STEP + b_offset;
               if (is_link) begin
                  link_we_next = 1'b1;
                  state_next   = S_WB;
               end else begin
                  retire_next   = 1'b1;
                  imem_req_next = 1'b1;
                  state_next    = S_FETCH;
               end
            end else if (is_ls) begin
               dmem_req_next = 1'b1;
               dmem_we_next  = !wr_reg;
               state_next    = S_MEM;
            end else begin
               rf_we_next   = wr_reg;
               cpsr_we_next = 1'b1;
               state_next   = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_req_q && mem.dmem_ack) begin
               if (wr_reg) begin
                  rf_we_next = 1'b1;
                  state_next = S_WB;
               end else begin
                  retire_next   = 1'b1;
                  imem_req_next = 1'b1;
                  state_next    = S_FETCH;
               end
            end else if (dmem_req_q && (wait_cnt == TIMEOUT_LAST)) begin
               fault_next = 1'b1;
               state_next = S_FAULT;
            end else begin
               dmem_req_next = 1'b1;
               if (dmem_req_q) wait_next = wait_cnt + 8'd1;
            end
         end
         S_WB: begin
            retire_next   = 1'b1;
            imem_req_next = 1'b1;
            state_next    = S_FETCH;
         end
         default: begin
            state_next = S_FAULT;
         end
      endcase
   end

   // Control state, PC/IR and registered strobes; reset overrides any ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         ir         <= 16'h0000;
         fault      <= 1'b0;
         wait_cnt   <= 8'd0;
         imem_req_q <= 1'b0;
         dmem_req_q <= 1'b0;
         dmem_we_q  <= 1'b0;
         alu_en     <= 1'b0;
         rf_we      <= 1'b0;
         link_we    <= 1'b0;
         cpsr_we    <= 1'b0;
         retire     <= 1'b0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         ir         <= ir_next;
         fault      <= fault_next;
         wait_cnt   <= wait_next;
         imem_req_q <= imem_req_next;
         dmem_req_q <= dmem_req_next;
         dmem_we_q  <= dmem_we_next;
         alu_en     <= alu_en_next;
         rf_we      <= rf_we_next;
         link_we    <= link_we_next;
         cpsr_we    <= cpsr_we_next;
         retire     <= retire_next;
      end
   end

   // Address of the instruction held in IR; pure data, needs no reset.
   always_ff @(posedge clk) begin
      ir_pc <= ir_pc_next;
   end

endmodule
